// File: rtl/fifo_axis_reader.sv
// Drains a 1-cycle-latency FIFO read port into an AXI4-Stream master with a 2-entry skid buffer.
// Optional word/packet counters are enabled by defining FIFO_AXIS_READER_WORD_CNT_EN.
module fifo_axis_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACKET_LEN     = 16,
    parameter int BEAT_CNT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_s_rst,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_rd_valid,
    input  logic                  i_fifo_empty,
    output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
    output logic                  o_m_axis_tvalid,
    input  logic                  i_m_axis_tready,
    output logic                  o_m_axis_tlast,
    output logic                  o_err
`ifdef FIFO_AXIS_READER_WORD_CNT_EN
    ,
    output logic [31:0]           o_word_cnt,
    output logic [31:0]           o_pkt_cnt
`endif
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(PACKET_LEN - 1);

    logic [DATA_WIDTH-1:0]     head_q;
    logic [DATA_WIDTH-1:0]     tail_q;
    logic [1:0]                count_q;
    logic                      in_flight_q;
    logic                      post_rst_q;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q;

    logic [1:0] credit;
    logic       pop;
    logic       push;
    logic       stray;

    assign credit = count_q + {1'b0, in_flight_q};
    assign pop    = o_m_axis_tvalid & i_m_axis_tready;
    // Only a read we actually requested may enter the buffer.
    assign push   = i_fifo_rd_valid & in_flight_q;
    // A read launched just before reset may still land in the first cycle after release.
    assign stray  = i_fifo_rd_valid & ~in_flight_q & ~post_rst_q;

    assign o_m_axis_tvalid = (count_q != 2'd0);
    assign o_m_axis_tdata  = head_q;
    assign o_m_axis_tlast  = o_m_axis_tvalid & (beat_cnt_q == LAST_BEAT);

    always_comb begin
        o_fifo_rd_en = 1'b0;
        if (!i_fifo_empty && !i_s_rst)
            o_fifo_rd_en = (credit < 2'd2) || ((credit == 2'd2) && pop);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read in this
    // block sees the pre-edge value and the order of statements does not matter.
    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            // NOTE: the two buffer words are reset because the head drives tdata, which
            // must read zero out of reset.
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
            in_flight_q <= 1'b0;
            post_rst_q  <= 1'b1;
            beat_cnt_q  <= '0;
            o_err       <= 1'b0;
        end else begin
            post_rst_q  <= 1'b0;
            in_flight_q <= o_fifo_rd_en;
            if (stray)
                o_err <= 1'b1;

            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= i_fifo_rd_data;
                    else                 tail_q <= i_fifo_rd_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= i_fifo_rd_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= i_fifo_rd_data;
                    end
                end
                default: ;
            endcase

            if (pop) begin
                if (beat_cnt_q == LAST_BEAT) beat_cnt_q <= '0;
                else                         beat_cnt_q <= beat_cnt_q + BEAT_CNT_WIDTH'(1);
            end
        end
    end

`ifdef FIFO_AXIS_READER_WORD_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            o_word_cnt <= '0;
            o_pkt_cnt  <= '0;
        end else begin
            if (pop && (o_word_cnt != '1))
                o_word_cnt <= o_word_cnt + 32'd1;
            if (pop && o_m_axis_tlast && (o_pkt_cnt != '1))
                o_pkt_cnt <= o_pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fifo_axis_reader.md
Name: fifo_axis_reader

Overview:
- Read-side controller for the team's synchronous FIFO. It drains words from the FIFO read port, which has a 1-cycle read latency (rd_en, then rd_data/rd_valid). It presents the words as an AXI4-Stream master with full backpressure support.
- Sustains 1 word/clk when tready is held high, without over-reading the FIFO.
- Generates tlast every PACKET_LEN beats.
- Sits between the FIFO and stream consumers such as DMA and serializer blocks.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and tdata
- PACKET_LEN, 16, beats per packet; tlast on the last beat; legal range 1..65535
- BEAT_CNT_WIDTH, 16, width of the internal beat counter; must hold PACKET_LEN-1

Ports:
- i_clk  in  1  clock
- i_s_rst  in  1  synchronous reset, active-high
- o_fifo_rd_en  out  1  read request to FIFO
- i_fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid with i_fifo_rd_valid
- i_fifo_rd_valid  in  1  FIFO read data valid, 1 clk after an accepted rd_en
- i_fifo_empty  in  1  FIFO empty flag
- o_m_axis_tdata  out  DATA_WIDTH  stream data
- o_m_axis_tvalid  out  1  stream valid
- i_m_axis_tready  in  1  stream ready
- o_m_axis_tlast  out  1  last beat of packet
- o_err  out  1  sticky protocol error

Behaviour:
- Interface: one clock, i_clk. i_s_rst is synchronous and active-high.
- Reset values:
  - o_fifo_rd_en = 0, o_m_axis_tvalid = 0, o_m_axis_tdata = 0, o_m_axis_tlast = 0, o_err = 0.
  - Buffer count = 0, in-flight flag = 0, beat counter = 0.
- Storage:
  - 2-entry output buffer (skid), head drives the tdata/tlast outputs.
  - in_flight flag = rd_en was issued last cycle.
  - credit = count + in_flight.
- Handshake:
  - pop = tvalid & tready.
  - o_fifo_rd_en = !i_fifo_empty & !i_s_rst & (credit < 2 | (credit == 2 & pop)). It is combinational from the registered state, i_fifo_empty and i_m_axis_tready.
  - The buffer never overflows: rd_valid always finds a free slot.
- Latency:
  - Word in a non-empty FIFO with an idle reader: rd_en at cycle N, rd_valid at N+1, tvalid registered high at N+2.
  - Back-to-back throughput is 1 word/clk with tready = 1.
- Stream rules:
  - tvalid = (count != 0).
  - tdata and tlast stay stable while tvalid & !tready.
  - Order is strictly FIFO order.
- Simultaneous events:
  - Push (rd_valid) and pop in the same cycle: count is unchanged. The head advances to the next entry and the new word enters the tail.
  - Push with count = 0: the word becomes head directly.
- tlast:
  - Beat counter increments on each pop. It wraps to 0 after the pop where it equals PACKET_LEN-1.
  - tlast = (beat counter == PACKET_LEN-1) while tvalid.
  - PACKET_LEN = 1 gives tlast on every beat.
- Empty:
  - No rd_en while i_fifo_empty = 1.
  - tvalid drops after the buffered words drain.
  - No bubbles are introduced beyond those caused by the FIFO being empty.
- Error:
  - i_fifo_rd_valid = 1 while in_flight = 0 sets o_err (sticky until reset). The stray word is discarded.
- Reset mid-operation:
  - Buffer and in-flight read are discarded, and tvalid drops the cycle after reset is sampled.
  - Beat counter returns to 0, so a partial packet is abandoned without tlast.
  - A rd_valid arriving in the first cycle after reset release is discarded and does not set o_err.

Optional Feature:
- Macro: FIFO_AXIS_READER_WORD_CNT_EN.
- Defined:
  - Adds output port o_word_cnt, 32 bits, reset 0.
  - Increments on every pop and saturates at 0xFFFF_FFFF.
  - Adds output port o_pkt_cnt, 32 bits, reset 0.
  - Increments on every pop with tlast and saturates.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Continuous drain: preload FIFO with 0x00..0x1F, PACKET_LEN = 16, tready = 1 → 32 consecutive beats 0x00..0x1F. tvalid first rises 2 clk after reset release. tlast on 0x0F and 0x1F only, with no gaps.
- Backpressure: 8 words 0xA0..0xA7, tready toggling 1,0,0,1 repeating → all 8 words delivered in order. tdata stays stable during stalls, o_fifo_rd_en is never asserted with credit ≥ 2 and no pop, and o_err = 0.
- Empty boundary: write 0x55 into an empty FIFO while tready = 1 → one rd_en pulse, one beat of 0x55, then tvalid = 0. No rd_en is issued while empty = 1.
- Simultaneous push/pop: FIFO holds 3 words 0x10,0x11,0x12, and tready goes low then high after the buffer fills → count stays ≤ 2, no word is lost or duplicated, and output is 0x10,0x11,0x12.
- Reset mid-packet: PACKET_LEN = 4, assert i_s_rst after beat 2 → tvalid = 0 the next clk and the beat counter restarts. After refill, the first beat has tlast = 0 and the 4th beat has tlast = 1.
- Error and counters: force i_fifo_rd_valid = 1 with no read outstanding → o_err = 1 and stays set. With FIFO_AXIS_READER_WORD_CNT_EN and 32 beats at PACKET_LEN = 16 → o_word_cnt = 32, o_pkt_cnt = 2.
